// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder.
package spike_dec_pkg;

    // Readout FSM: IDLE waits for a window end, DRAIN streams the snapshot.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Width of a channel index; never less than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Saturation ceiling of a w-bit counter (w up to 31).
    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter with priority clear.
module spike_sat_counter
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_nxt_o is the count including this cycle's spike, before any clear;
    // the top snapshots it on the window-end cycle.
    assign cnt_nxt_o = (inc && (cnt_q != MAX_CNT)) ? cnt_q + 1'b1 : cnt_q;

    // Clear wins over increment; otherwise count only on enabled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_nxt_o;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a programmable window and streams each
// window's counts out one channel per transfer.
//
// Read handshake: a word moves on every cycle where rd_valid && rd_ready.
// rd_valid depends only on registered state, and while it is high without
// rd_ready the word (rd_data, rd_ch, rd_last) is held unchanged.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         spike_in,
    input  logic [WIN_W-1:0]          win_len,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [CNT_W-1:0]          rd_data,
    output logic [ch_w(NUM_CH)-1:0]   rd_ch,
    output logic                      rd_last,
    output logic                      overrun,
    output state_e                    dbg_state
);

    localparam int              CH_W    = ch_w(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [WIN_W-1:0] win_len_q, win_len_d;
    logic [WIN_W-1:0] eff_len;
    logic             wend;

    logic [CNT_W-1:0] cnt_nxt [NUM_CH];
    logic [CNT_W-1:0] shadow_q [NUM_CH];

    state_e           state_q, state_d;
    logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
    logic             ovr_q, ovr_d;
    logic             load;

    // Window timing: a new length is only picked up on a window's first cycle.
    always_comb begin
        eff_len   = (wcnt_q == '0) ? win_len : win_len_q;
        wend      = en && (wcnt_q == eff_len);
        wcnt_d    = wcnt_q;
        win_len_d = win_len_q;
        if (en) begin
            if (wcnt_q == '0) begin
                win_len_d = win_len;
            end
            wcnt_d = wend ? '0 : wcnt_q + 1'b1;
        end
    end

    // Window counter and latched length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            win_len_q <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            win_len_q <= win_len_d;
        end
    end

    // One saturating counter per channel; window end restarts them at zero.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .inc       (spike_in[g]),
            .clr       (wend),
            .cnt_nxt_o (cnt_nxt[g])
        );
    end

    // Readout FSM: snapshot on window end when idle, else flag an overrun.
    always_comb begin
        state_d = state_q;
        rd_ch_d = rd_ch_q;
        ovr_d   = ovr_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wend) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                    rd_ch_d = '0;
                end
            end
            DRAIN: begin
                if (wend) begin
                    ovr_d = 1'b1;
                end
                if (rd_ready) begin
                    if (rd_ch_q == LAST_CH) begin
                        state_d = IDLE;
                        rd_ch_d = '0;
                    end else begin
                        rd_ch_d = rd_ch_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, channel pointer and sticky overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_ch_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_ch_q <= rd_ch_d;
            ovr_q   <= ovr_d;
        end
    end

    // Shadow bank captures the closing window's final counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= cnt_nxt[i];
            end
        end
    end

    assign rd_valid  = (state_q == DRAIN);
    assign rd_ch     = rd_ch_q;
    assign rd_last   = rd_valid && (rd_ch_q == LAST_CH);
    assign rd_data   = rd_valid ? shadow_q[rd_ch_q] : '0;
    assign overrun   = ovr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random
// traffic, all compared against a window/queue level reference model.
module tb_spike_rate_decoder;
    import spike_dec_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int WIN_W  = 8;
    localparam int MAXC   = 255;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NUM_CH-1:0] spike_in = '0;
    logic [WIN_W-1:0]  win_len = '0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [1:0]        rd_ch;
    logic              rd_last;
    logic              overrun;
    state_e            dbg_state;

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spike_in  (spike_in),
        .win_len   (win_len),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_ch     (rd_ch),
        .rd_last   (rd_last),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_q[$];      // words still owed to the consumer
    int               m_pos;         // enabled cycles elapsed in the window
    int               m_len;         // window length-1 latched at window start
    int               m_cnt[NUM_CH]; // raw spike totals this window
    bit               m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pos = 0;
        m_len = 0;
        m_ovr = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    endtask

    // What the next rising edge does, in terms of windows and queued words.
    task automatic model_step(input logic e, input logic [NUM_CH-1:0] sp,
                              input logic [WIN_W-1:0] wl, input logic rdy);
        bit busy;
        busy = (exp_q.size() > 0);
        if (busy && rdy) void'(exp_q.pop_front());
        if (e) begin
            if (m_pos == 0) m_len = int'(wl);
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] += int'(sp[i]);
            if (m_pos == m_len) begin
                if (busy) begin
                    m_ovr = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++)
                        exp_q.push_back(CNT_W'((m_cnt[i] > MAXC) ? MAXC : m_cnt[i]));
                end
                for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        chk("rd_valid", 32'(rd_valid), 32'(sz > 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("state_drain", 32'(dbg_state == DRAIN), 32'(sz > 0));
        if (sz > 0) begin
            chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
            chk("rd_ch", 32'(rd_ch), 32'(NUM_CH - sz));
            chk("rd_last", 32'(rd_last), 32'(sz == 1));
        end else begin
            chk("rd_last_idle", 32'(rd_last), 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive, predict, clock, then compare.
    task automatic cycle(input logic e, input logic [NUM_CH-1:0] sp,
                         input logic [WIN_W-1:0] wl, input logic rdy);
        en       = e;
        spike_in = sp;
        win_len  = wl;
        rd_ready = rdy;
        model_step(e, sp, wl, rdy);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        spike_in = '0;
        rd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_ch", 32'(rd_ch), 32'd0);
        check_outputs();
        rst_n = 1'b1;
    endtask

    function automatic logic [NUM_CH-1:0] rnd_spk();
        return NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
    endfunction

    // ---------------- stimulus ----------------
    logic [CNT_W-1:0] t1_exp[NUM_CH];
    int               t1_seen;
    bit               reached;

    initial begin
        t1_exp[0] = 8'd10; t1_exp[1] = 8'd5; t1_exp[2] = 8'd0; t1_exp[3] = 8'd2;
        @(negedge clk);
        do_reset();

        // Basic window: fixed per-channel patterns, consumer always ready.
        t1_seen = 0;
        for (int c = 0; c < 18; c++) begin
            logic [NUM_CH-1:0] sp;
            sp    = '0;
            sp[0] = 1'b1;
            sp[1] = (m_pos % 2 == 0);
            sp[3] = (m_pos == 0) || (m_pos == 9);
            cycle(1'b1, (c < 10) ? sp : 4'b0000, 8'd9, 1'b1);
            if (rd_valid && t1_seen < NUM_CH) begin
                chk("t1_word", 32'(rd_data), 32'(t1_exp[t1_seen]));
                t1_seen++;
            end
        end
        chk("t1_words_seen", 32'(t1_seen), 32'(NUM_CH));

        // Long window on a saturating channel, two windows back to back.
        for (int c = 0; c < 530; c++)
            cycle(1'b1, {rnd_spk() & 4'b1110} | 4'b0001, 8'd255, 1'b1);

        // Stalled consumer across the next window end -> overrun.
        do_reset();
        for (int c = 0; c < 31; c++) cycle(1'b1, rnd_spk(), 8'd9, 1'b0);
        for (int c = 0; c < 20; c++) cycle(1'b1, rnd_spk(), 8'd9, 1'b1);

        // Count enable paused mid-window.
        do_reset();
        for (int c = 0; c < 25; c++)
            cycle((c < 3 || c > 7), 4'b0001, 8'd9, 1'b1);

        // Window length changed mid-window: takes effect at the next window.
        do_reset();
        for (int c = 0; c < 30; c++)
            cycle(1'b1, 4'b0001 | (rnd_spk() & 4'b0110), (c < 5) ? 8'd9 : 8'd3, 1'b1);

        // Async reset in the middle of a drain, with overrun already set.
        do_reset();
        for (int c = 0; c < 12; c++) cycle(1'b1, rnd_spk(), 8'd3, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            cycle(1'b1, rnd_spk(), 8'd3, (exp_q.size() > 2));
            if (exp_q.size() == 2) reached = 1'b1;
        end
        chk("t6_reach_ch2", 32'(reached), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_valid", 32'(rd_valid), 32'd0);
        chk("t6_async_ch", 32'(rd_ch), 32'd0);
        chk("t6_async_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) cycle(1'b1, rnd_spk(), 8'd3, 1'b1);

        // Random traffic: short windows (including one-cycle), random
        // enable gaps and consumer back-pressure.
        do_reset();
        for (int c = 0; c < 800; c++)
            cycle(($urandom_range(0, 9) != 0), rnd_spk(),
                  WIN_W'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));

        // Random traffic with a one-cycle window and a steady reader.
        do_reset();
        for (int c = 0; c < 60; c++)
            cycle(1'b1, rnd_spk(), 8'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
